song_sequencer: RTL
===================

Name: song_sequencer

Overview:
- Initiator side of the play_note val/rdy interface consumed by the multi-note player.
- Holds a small programmable song: up to DEPTH 3-bit note numbers, where 0 = rest and 1-7 = note select.
- On start, presents the notes in order to the player, one per val/rdy transfer. Optionally loops until stopped.
- Sits between the switch/button front end and the note player on the FPGA top level.

Parameters:
- DEPTH, 8, number of song entries (power of two).
- AW, 3, log2(DEPTH): address and index width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- wr_en  input  1  write one song entry this cycle.
- wr_addr  input  AW  entry index to write.
- wr_data  input  3  note number to store (0 = rest).
- song_len  input  AW+1  number of entries to play, valid range 1..DEPTH.
- loop  input  1  replay from entry 0 after the last entry; sampled at start.
- start  input  1  single-cycle pulse that begins playback.
- stop  input  1  single-cycle pulse that aborts playback.
- play_note_val  output  1  request valid.
- play_note_rdy  input  1  player ready.
- play_note_num  output  3  note number being requested.
- busy  output  1  playback in progress.
- note_idx  output  AW  index of the entry currently presented.

Behaviour:
- Reset values (asynchronous, all forced to 0):
  - play_note_val=0, play_note_num=0, busy=0, note_idx=0.
  - State = IDLE.
  - All song entries cleared to 0 (rest).
  - Latched length and loop flag cleared.
- FSM states: IDLE, ISSUE.
  - play_note_val = (state==ISSUE).
  - busy = (state==ISSUE).
  - play_note_num = mem[note_idx] in ISSUE, 0 in IDLE.
  - All outputs are decoded from registered state/index only; there is no combinational path from play_note_rdy to any output.
- Memory writes:
  - In IDLE, wr_en writes mem[wr_addr] <= wr_data at the clock edge.
  - In ISSUE, wr_en is ignored, so a presented note never changes under val.
- IDLE -> ISSUE:
  - Occurs on start=1 with song_len in 1..DEPTH.
  - Latches len=song_len and loop_q=loop; sets note_idx=0.
  - play_note_val rises the cycle after the start edge (latency 1).
  - start with song_len=0 is ignored and the block stays IDLE.
  - song_len > DEPTH is clamped to DEPTH.
- Transfer (fire) occurs when play_note_val & play_note_rdy at a clock edge.
  - Until fire, play_note_val and play_note_num are held stable.
- On fire in ISSUE:
  - If note_idx != len-1: note_idx increments and the block stays in ISSUE. The next note is presented the very next cycle, giving back-to-back transfers at one per cycle when rdy is held high.
  - If note_idx == len-1 and loop_q=1: note_idx wraps to 0 and the block stays in ISSUE.
  - If note_idx == len-1 and loop_q=0: the block goes to IDLE and note_idx resets to 0.
- stop in ISSUE:
  - Next state is IDLE and note_idx=0. This is the only case where val drops without a fire.
  - If stop and fire occur in the same cycle, the transfer counts (the player accepted it) and the block still goes to IDLE.
- stop in IDLE is ignored.
- start while in ISSUE is ignored; len and loop_q are unchanged.
- stop and start in the same cycle: stop wins.
  - From ISSUE the block goes to IDLE.
  - From IDLE the block stays IDLE.
- Changes to song_len or loop during playback have no effect; the latched copies are used.
- Reset asserted mid-playback:
  - Outputs drop to the reset values immediately, without waiting for a clock edge.
  - Song contents are lost.
- Rest entries (0) are transferred like any other note. The player defines what a rest means; this block has no special case for them.

Test Plan:
- Reset, then write mem[0..2]=3,5,7 in IDLE, song_len=3, loop=0, pulse start, hold rdy=1 -> val high for 3 consecutive cycles with num=3,5,7 and note_idx=0,1,2; then val=0, busy=0, note_idx=0.
- Same song with rdy low for 10 cycles before each fire -> num stays stable at each value until rdy=1; exactly 3 transfers occur; no glitch on val.
- song_len=2, loop=1, mem=1,2, rdy=1 -> transfer sequence 1,2,1,2,1...; pulse stop after the 5th fire -> val=0 on the next cycle, and no 6th transfer.
- During ISSUE: wr_en to mem[1] with wr_data=6, and a second start pulse -> stored song is unchanged, and the sequence is unaffected; in IDLE the same write takes effect.
- start with song_len=0 -> busy stays 0. start with song_len=15 -> exactly 8 transfers.
- Assert rst asynchronously mid-cycle while val=1 -> val, busy, num and note_idx go to 0 before the next clock edge; after release, all entries read as 0.

Source files
------------

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : song_sequencer
//  Purpose  : Holds a small programmable song of 3-bit note numbers and
//             plays it out in order over the play_note val/rdy interface,
//             once or looping until stopped.
//  Revision : 1.0  initial release
// ============================================================================
module song_sequencer #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [2:0]    wr_data,
   input  logic [AW:0]   song_len,
   input  logic          loop,
   input  logic          start,
   input  logic          stop,
   output logic          play_note_val,
   input  logic          play_note_rdy,
   output logic [2:0]    play_note_num,
   output logic          busy,
   output logic [AW-1:0] note_idx
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_len_one = (AW+1)'(1);
   localparam logic [AW-1:0] c_idx_one = AW'(1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_idx;
   logic [AW-1:0] w_idx_nxt;
   logic [AW:0]   r_len;
   logic          r_loop;
   logic          w_load;
   logic [2:0]    r_mem [DEPTH];

   logic [AW:0]   w_len_clamp;
   logic          w_issue;
   logic          w_fire;
   logic          w_last;

   // Oversized lengths are clamped so playback never runs past the table.
   assign w_len_clamp = (song_len > c_depth) ? c_depth : song_len;
   assign w_issue     = (r_state == S_ISSUE);
   assign w_fire      = w_issue & play_note_rdy;
   assign w_last      = ({1'b0, r_idx} == (r_len - c_len_one));

   // Outputs decode only registered state, so rdy never reaches them combinationally.
   assign play_note_val = w_issue;
   assign busy          = w_issue;
   assign note_idx      = r_idx;
   assign play_note_num = w_issue ? r_mem[r_idx] : 3'd0;

   // State and index register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next-state and next-index decode; stop overrides both start and fire.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !stop && (song_len != '0)) begin
               w_state_nxt = S_ISSUE;
               w_idx_nxt   = '0;
               w_load      = 1'b1;
            end
         end
         S_ISSUE: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
            end else if (w_fire) begin
               if (!w_last) begin
                  w_idx_nxt = r_idx + c_idx_one;
               end else if (r_loop) begin
                  w_idx_nxt = '0;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_idx_nxt   = '0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Playback length and loop mode are captured at start and held for the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len  <= '0;
         r_loop <= 1'b0;
      end else if (w_load) begin
         r_len  <= w_len_clamp;
         r_loop <= loop;
      end
   end

   // Song table: writable only while idle so a presented note cannot change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 3'd0;
         end
      end else if (wr_en && !w_issue) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

endmodule
`default_nettype wire
